// File: rtl/serial_adder_nbit.sv
// Digit-serial adder: {cout,sum} = a + b + cin, DIGIT bits per clock, LSB slice first.
// Latency N=WIDTH/DIGIT RUN cycles after accept; start ignored while busy. Optional ADDSUB_MODE_EN adds a sub port.

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_nbit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef ADDSUB_MODE_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("serial_adder_nbit: DIGIT must be >= 1 and divide WIDTH");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] psum_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [DIGIT:0]   rc;
    logic [DIGIT-1:0] slice_sum;
    logic [WIDTH-1:0] b_eff;
    logic             c_eff;

    // Subtraction is a + ~b + 1: invert B and force the carry-in at capture time.
`ifdef ADDSUB_MODE_EN
    assign b_eff = sub ? ~b : b;
    assign c_eff = sub ? 1'b1 : cin;
`else
    assign b_eff = b;
    assign c_eff = cin;
`endif

    assign rc[0] = carry;

    genvar i;
    generate
        for (i = 0; i < DIGIT; i++) begin : g_fa
            full_adder u_fa (
                .a  (opa[i]),
                .b  (opb[i]),
                .ci (rc[i]),
                .s  (slice_sum[i]),
                .co (rc[i+1])
            );
        end
    endgenerate

    // New slice enters at the top so slice 0 ends up at the bottom after N shifts.
    always_comb begin
        psum_nxt = psum >> DIGIT;
        psum_nxt[WIDTH-1 -: DIGIT] = slice_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            psum  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b_eff;
                        carry <= c_eff;
                        psum  <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    opa   <= opa >> DIGIT;
                    opb   <= opb >> DIGIT;
                    carry <= rc[DIGIT];
                    psum  <= psum_nxt;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        sum   <= psum_nxt;
                        cout  <= rc[DIGIT];
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_adder_nbit.sv
// Scoreboard bench for serial_adder_nbit in three configurations (1/1, 8/1, 8/4); sub tests under ADDSUB_MODE_EN.
module tb_serial_adder_nbit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // WIDTH=1, DIGIT=1
    logic start1 = 0, cin1 = 0, busy1, done1, cout1;
    logic [0:0] a1 = '0, b1 = '0, sum1;
    // WIDTH=8, DIGIT=1
    logic start8 = 0, cin8 = 0, busy8, done8, cout8;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    // WIDTH=8, DIGIT=4
    logic start4 = 0, cin4 = 0, busy4, done4, cout4;
    logic [7:0] a4 = '0, b4 = '0, sum4;
`ifdef ADDSUB_MODE_EN
    logic sub1 = 0, sub8 = 0, sub4 = 0;
`endif

    serial_adder_nbit #(.WIDTH(1), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
`ifdef ADDSUB_MODE_EN
        .sub(sub1),
`endif
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

    serial_adder_nbit #(.WIDTH(8), .DIGIT(1)) u_d8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef ADDSUB_MODE_EN
        .sub(sub8),
`endif
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));

    serial_adder_nbit #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
`ifdef ADDSUB_MODE_EN
        .sub(sub4),
`endif
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4));

    logic [1:0] q1[$];
    logic [8:0] q8[$];
    logic [8:0] q4[$];

    // Monitors: pop expected {cout,sum} whenever a done pulse is seen.
    always @(negedge clk) begin
        if (done1) begin
            check("d1_sb_nonempty", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) check("d1_result", 32'({cout1, sum1}), 32'(q1.pop_front()));
        end
        if (done8) begin
            check("d8_sb_nonempty", 32'(q8.size() != 0), 32'd1);
            if (q8.size() != 0) check("d8_result", 32'({cout8, sum8}), 32'(q8.pop_front()));
        end
        if (done4) begin
            check("d4_sb_nonempty", 32'(q4.size() != 0), 32'd1);
            if (q4.size() != 0) check("d4_result", 32'({cout4, sum4}), 32'(q4.pop_front()));
        end
    end

    // One 8-bit add on the DIGIT=1 instance; operands are zeroed right after acceptance.
    task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                        input logic sv, input logic [8:0] exp, input string tag);
        int cyc;
        @(negedge clk);
        a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
`ifdef ADDSUB_MODE_EN
        sub8 = sv;
`else
        if (sv) $display("note: sub requested without ADDSUB_MODE_EN (%s)", tag);
`endif
        q8.push_back(exp);
        @(posedge clk); #1;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        cyc = 0;
        while (busy8 && cyc < 20) begin
            cyc++;
            @(posedge clk); #1;
        end
        check({tag, "_busy_cycles"}, 32'(cyc), 32'd8);
        check({tag, "_done_high"}, 32'(done8), 32'd1);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, 32'(done8), 32'd0);
    endtask

    // a/b/cin per bit 2/1/0, expected {cout,sum}.
    logic [2:0] v1 [8] = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b001, 3'b011, 3'b101, 3'b111};
    logic [1:0] e1 [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] v;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        check("rst_sum", 32'(sum8), 32'd0);
        check("rst_cout", 32'(cout8), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // WIDTH=1 exhaustive
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            v = v1[k];
            a1 = v[2]; b1 = v[1]; cin1 = v[0]; start1 = 1'b1;
            q1.push_back(e1[k]);
            @(posedge clk); #1;
            start1 = 1'b0;
            check("d1_busy_after_accept", 32'(busy1), 32'd1);
            check("d1_done_early", 32'(done1), 32'd0);
            @(posedge clk); #1;
            check("d1_done", 32'(done1), 32'd1);
            check("d1_busy_clear", 32'(busy1), 32'd0);
        end

        run8(8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, "ff_01");
        run8(8'hA5, 8'h5A, 1'b1, 1'b0, 9'h100, "a5_5a");
        run8(8'h12, 8'h34, 1'b0, 1'b0, 9'h046, "no_resample");

        // Asynchronous reset three slices into an add.
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h0F; cin8 = 1'b1; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_sum_held", 32'(sum8), 32'h46);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy8), 32'd0);
        check("mid_rst_done", 32'(done8), 32'd0);
        check("mid_rst_sum", 32'(sum8), 32'd0);
        check("mid_rst_cout", 32'(cout8), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        run8(8'h80, 8'h80, 1'b1, 1'b0, 9'h101, "after_rst");

        // DIGIT=4 with start held high: second op accepted in the done cycle.
        @(negedge clk);
        a4 = 8'h3C; b4 = 8'h47; cin4 = 1'b0; start4 = 1'b1;
        q4.push_back(9'h083);
        @(posedge clk); #1;
        check("d4_busy_e0", 32'(busy4), 32'd1);
        a4 = 8'hFF; b4 = 8'hFF; cin4 = 1'b1;
        @(posedge clk); #1;
        check("d4_busy_e1", 32'(busy4), 32'd1);
        check("d4_done_e1", 32'(done4), 32'd0);
        @(posedge clk); #1;
        check("d4_busy_e2", 32'(busy4), 32'd0);
        check("d4_done_e2", 32'(done4), 32'd1);
        a4 = 8'h10; b4 = 8'h20; cin4 = 1'b1;
        q4.push_back(9'h031);
        @(posedge clk); #1;
        check("d4_b2b_accept", 32'(busy4), 32'd1);
        start4 = 1'b0;
        @(posedge clk); #1;
        check("d4_busy_e4", 32'(busy4), 32'd1);
        @(posedge clk); #1;
        check("d4_done_e5", 32'(done4), 32'd1);
        check("d4_busy_e5", 32'(busy4), 32'd0);

`ifdef ADDSUB_MODE_EN
        run8(8'h05, 8'h07, 1'b0, 1'b1, 9'h0FE, "sub_5_7");
        run8(8'h07, 8'h05, 1'b1, 1'b1, 9'h102, "sub_7_5");
        run8(8'h07, 8'h05, 1'b1, 1'b0, 9'h00D, "add_after_sub");
`endif

        repeat (4) @(posedge clk);
        #1;
        check("d1_sb_drained", 32'(q1.size()), 32'd0);
        check("d8_sb_drained", 32'(q8.size()), 32'd0);
        check("d4_sb_drained", 32'(q4.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
